// File: rtl/router_input_fifo_pkg.sv
// Shared router definitions: flit width default, input FIFO depth,
// one-hot output-port identifiers (N, E, W, S, L) used by the input FIFOs,
// arbiters and crossbar, and the RTS/CTS handshake state encoding.
package router_input_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned NUM_PORTS      = 5;

  // One-hot port identifiers; bit position doubles as the port index.
  localparam logic [NUM_PORTS-1:0] PORT_N = 5'b00001;
  localparam logic [NUM_PORTS-1:0] PORT_E = 5'b00010;
  localparam logic [NUM_PORTS-1:0] PORT_W = 5'b00100;
  localparam logic [NUM_PORTS-1:0] PORT_S = 5'b01000;
  localparam logic [NUM_PORTS-1:0] PORT_L = 5'b10000;

  // Receive-side handshake: IDLE while CTS is low, ACK for the single
  // cycle CTS is high.
  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

  // Grants are one-hot by construction, but any combination still
  // collapses to a single pop request.
  function automatic logic any_grant(input logic [NUM_PORTS-1:0] grants);
    return |grants;
  endfunction

endpackage

// File: rtl/router_input_fifo_handshake_ctrl.sv
// fifo_handshake_ctrl: receive-side RTS/CTS handshake and FIFO write/read
// enable generation for one router input port.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   drts_i   : upstream request-to-send
//   full_i   : FIFO holds DEPTH flits
//   empty_i  : FIFO holds no flits
//   grant_i  : per-output-port pop requests (one-hot, PORT_* bit order)
//   cts_o    : registered clear-to-send pulse to upstream
//   wr_en_o  : store the incoming flit on this edge
//   rd_en_o  : pop the head flit on this edge
module fifo_handshake_ctrl
  import router_input_fifo_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 drts_i,
  input  logic                 full_i,
  input  logic                 empty_i,
  input  logic [NUM_PORTS-1:0] grant_i,
  output logic                 cts_o,
  output logic                 wr_en_o,
  output logic                 rd_en_o
);

  hs_state_e state_q, state_d;
  logic      cts_q;

  // ACK is entered only from IDLE, so CTS can never stay high for two
  // consecutive cycles: a continuously asserted DRTS yields 1,0,1,0...
  always_comb begin
    state_d = HS_IDLE;
    if ((state_q == HS_IDLE) && drts_i && !full_i) begin
      state_d = HS_ACK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HS_IDLE;
      cts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cts_q   <= (state_d == HS_ACK);
    end
  end

  // The flit is captured on the same edge that CTS rises.
  assign wr_en_o = drts_i & (state_d == HS_ACK);
  assign rd_en_o = any_grant(grant_i) & ~empty_i;
  assign cts_o   = cts_q;

endmodule

// File: rtl/router_input_fifo.sv
// router_input_fifo: per-input-port flit buffer for the 5-port NoC router.
// Accepts flits over the RTS/CTS handshake into a circular FIFO and exposes
// the head flit combinationally; any output-port grant pops the head.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   RX         : incoming flit, valid while DRTS=1
//   DRTS       : upstream request-to-send
//   CTS        : clear-to-send pulse to upstream
//   read_en_*  : pop requests from the N/E/W/S/L output arbiters
//   Data_out   : head flit (don't-care while empty)
//   empty/full : occupancy flags decoded from count
//   count      : occupancy, 0..DEPTH
module router_input_fifo
  import router_input_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = FIFO_DEPTH,
  localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [NUM_PORTS-1:0]  grants;
  logic                  wr_en;
  logic                  rd_en;

  assign grants = ({NUM_PORTS{read_en_N}} & PORT_N)
                | ({NUM_PORTS{read_en_E}} & PORT_E)
                | ({NUM_PORTS{read_en_W}} & PORT_W)
                | ({NUM_PORTS{read_en_S}} & PORT_S)
                | ({NUM_PORTS{read_en_L}} & PORT_L);

  fifo_handshake_ctrl u_hs_ctrl (
    .clk_i   (clk),
    .rst_ni  (rst),
    .drts_i  (DRTS),
    .full_i  (full),
    .empty_i (empty),
    .grant_i (grants),
    .cts_o   (CTS),
    .wr_en_o (wr_en),
    .rd_en_o (rd_en)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; Data_out is don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= RX;
    end
  end

  assign Data_out = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_DEPTH);
  assign count    = count_q;

endmodule

// File: tb/tb_router_input_fifo.sv
module tb_router_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] RX;
  logic          DRTS;
  logic          CTS;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [DW-1:0] Data_out;
  logic          empty, full;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model: flit queue plus the "CTS was high last cycle" flag.
  logic [DW-1:0] exp_q [$];
  bit            exp_cts;
  bit            last_push, last_pop;

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .CTS       (CTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic set_reads(input logic [4:0] v);
    {read_en_L, read_en_S, read_en_W, read_en_E, read_en_N} = v;
  endtask

  // Advance one clock edge, applying the handshake/FIFO rules to the model,
  // and return 1 time unit after the edge.
  task automatic tick();
    bit            push, pop;
    logic [DW-1:0] rx_s;
    pop  = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) && (exp_q.size() > 0);
    push = !exp_cts && DRTS && (exp_q.size() < DEPTH);
    rx_s = RX;
    @(posedge clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(rx_s);
    exp_cts   = push;
    last_push = push;
    last_pop  = pop;
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    DRTS = 1'b0;
    RX   = '0;
    set_reads(5'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cts = 0;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    DRTS = 1'b1;
    RX   = 32'h1234_5678;
    set_reads(5'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (CTS !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: CTS=%b empty=%b full=%b count=%0d, expected CTS=0 empty=1 full=0 count=0",
               CTS, empty, full, count);
    end
    rst = 1'b1;
    exp_q.delete();
    exp_cts = 0;
    tick();
    checks++;
    if (CTS !== 1'b1 || count !== 3'd1 || Data_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_first_cts: CTS=%b count=%0d data=%h, expected CTS=1 count=1 data=12345678",
               CTS, count, Data_out);
    end
    DRTS = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    RX   = 32'hDEAD_BEEF;
    DRTS = 1'b1;
    tick();
    checks++;
    if (CTS !== 1'b1 || Data_out !== 32'hDEAD_BEEF || count !== 3'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_write: CTS=%b data=%h count=%0d empty=%b, expected 1 deadbeef 1 0",
               CTS, Data_out, count, empty);
    end
    tick();
    DRTS = 1'b0;
    checks++;
    if (CTS !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_cts_width: CTS=%b count=%0d, expected CTS=0 count=1", CTS, count);
    end
    set_reads(5'b00010);
    tick();
    set_reads(5'b0);
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: empty=%b count=%0d, expected empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    do_reset();
    DRTS = 1'b1;
    for (int i = 0; i < 14; i++) begin
      RX = $urandom;
      tick();
      if (CTS === 1'b1) pulses++;
      checks++;
      if (CTS !== exp_cts || count !== 3'(exp_q.size())) begin
        errors++;
        $display("FAIL fill_cycle%0d: CTS=%b count=%0d, expected CTS=%b count=%0d",
                 i, CTS, count, exp_cts, exp_q.size());
      end
    end
    checks++;
    if (pulses != 4 || full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_final: pulses=%0d full=%b count=%0d, expected pulses=4 full=1 count=4",
               pulses, full, count);
    end
  endtask

  // Relies on test_fill leaving the FIFO full with DRTS held high.
  task automatic test_full_pop();
    logic [DW-1:0] head;
    head = exp_q[0];
    RX   = 32'hCAFE_0001;
    set_reads(5'b01000);
    checks++;
    if (Data_out !== head) begin
      errors++;
      $display("FAIL full_head: data=%h, expected %h", Data_out, head);
    end
    tick();
    set_reads(5'b0);
    checks++;
    if (count !== 3'd3 || CTS !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_edge: count=%0d CTS=%b full=%b, expected 3 0 0", count, CTS, full);
    end
    tick();
    DRTS = 1'b0;
    checks++;
    if (count !== 3'd4 || CTS !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_refill: count=%0d CTS=%b full=%b, expected 4 1 1", count, CTS, full);
    end
    set_reads(5'b00001);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Data_out !== exp_q[0]) begin
        errors++;
        $display("FAIL full_drain%0d: data=%h, expected %h", i, Data_out, exp_q[0]);
      end
      tick();
    end
    set_reads(5'b0);
  endtask

  task automatic test_wrap_order();
    int sent = 0;
    int recv = 0;
    do_reset();
    for (int cyc = 0; cyc < 80 && recv < 6; cyc++) begin
      DRTS = (sent < 6);
      RX   = 32'(sent);
      read_en_W = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      if (read_en_W) begin
        checks++;
        if (Data_out !== 32'(recv)) begin
          errors++;
          $display("FAIL wrap_order%0d: data=%h, expected %h", recv, Data_out, 32'(recv));
        end
      end
      tick();
      if (last_push) sent++;
      if (last_pop)  recv++;
    end
    read_en_W = 1'b0;
    DRTS = 1'b0;
    checks++;
    if (recv != 6 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: received=%0d empty=%b, expected 6 1", recv, empty);
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    set_reads(5'b11111);
    tick();
    tick();
    set_reads(5'b0);
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL empty_pop: empty=%b count=%0d, expected 1 0", empty, count);
    end
    // Two flits in, then a double grant must pop exactly one.
    DRTS = 1'b1;
    RX = 32'hA5A5_0000;
    tick();
    tick();
    RX = 32'hA5A5_1111;
    tick();
    DRTS = 1'b0;
    checks++;
    if (count !== 3'd2 || Data_out !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL empty_pop_ptrs: count=%0d data=%h, expected 2 a5a50000", count, Data_out);
    end
    set_reads(5'b10001);
    tick();
    set_reads(5'b0);
    checks++;
    if (count !== 3'(exp_q.size()) || Data_out !== exp_q[0] || count !== 3'd1) begin
      errors++;
      $display("FAIL double_grant: count=%0d data=%h, expected 1 %h", count, Data_out, exp_q[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    DRTS = 1'b1;
    RX = 32'h0000_0011;
    tick();
    tick();
    RX = 32'h0000_0022;
    tick();
    checks++;
    if (CTS !== 1'b1 || count !== 3'd2) begin
      errors++;
      $display("FAIL async_setup: CTS=%b count=%0d, expected 1 2", CTS, count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (CTS !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: CTS=%b count=%0d empty=%b full=%b, expected 0 0 1 0",
               CTS, count, empty, full);
    end
    DRTS = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cts = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      DRTS = ($urandom_range(0, 3) != 0);
      RX   = $urandom;
      if ($urandom_range(0, 2) == 0) set_reads(5'($urandom));
      else                           set_reads(5'b0);
      tick();
      checks++;
      if (CTS !== exp_cts || count !== 3'(exp_q.size()) ||
          empty !== (exp_q.size() == 0) || full !== (exp_q.size() == DEPTH)) begin
        errors++;
        $display("FAIL random_ctrl%0d: CTS=%b count=%0d empty=%b full=%b, expected CTS=%b count=%0d",
                 i, CTS, count, empty, full, exp_cts, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (Data_out !== exp_q[0]) begin
          errors++;
          $display("FAIL random_data%0d: data=%h, expected %h", i, Data_out, exp_q[0]);
        end
      end
    end
    DRTS = 1'b0;
    set_reads(5'b0);
  endtask

  initial begin
    rst  = 1'b0;
    DRTS = 1'b0;
    RX   = '0;
    set_reads(5'b0);
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_wrap_order();
    test_empty_pop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_fifo.md
# router_input_fifo

Per-input-port flit buffer for the 5-port NoC router. It accepts flits from the upstream router or local core over the RTS/CTS two-phase handshake, and stores them in a small circular FIFO. It presents the head flit to the routing logic and crossbar, and pops the head when any output-port arbiter grants this input. One instance sits in front of each of the N, E, W, S and L inputs, directly upstream of the arbiters' `Req_*` / `Grant_*` interface.

## Interface
- `DATA_WIDTH`, 32: flit width in bits.
- `DEPTH`, 4: FIFO slots. Must be a power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width. Derived, not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `RX`  in  DATA_WIDTH  incoming flit, valid while `DRTS`=1.
- `DRTS`  in  1  upstream request-to-send (the upstream block's `RTS`).
- `CTS`  out  1  clear-to-send pulse to upstream (drives upstream `DCTS`).
- `read_en_N`, `read_en_E`, `read_en_W`, `read_en_S`, `read_en_L`  in  1 each  pop requests, one per output-port arbiter grant for this input.
- `Data_out`  out  DATA_WIDTH  head flit, combinational from storage.
- `empty`  out  1  FIFO holds no flits.
- `full`  out  1  FIFO holds DEPTH flits.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage is DEPTH×DATA_WIDTH registers with binary `rd_ptr`/`wr_ptr` of PTR_W bits, wrapping modulo DEPTH, plus a PTR_W+1-bit occupancy counter. `full` = (count==DEPTH) and `empty` = (count==0), both decoded from the counter.
- Handshake register `CTS_FF` drives `CTS`. Its next value is 1 iff `CTS_FF`=0, `DRTS`=1 and `full`=0; otherwise it is 0.
  - The handshake therefore has two states: IDLE (`CTS_FF`=0) and ACK (`CTS_FF`=1).
  - ACK lasts exactly one cycle, then returns to IDLE. This mirrors upstream `RTS_FF`, which clears when it samples `RTS_FF & DCTS`.
- `wr_en` = `DRTS` & next-`CTS_FF`. `RX` is written at `wr_ptr` on the same edge that `CTS_FF` rises, then `wr_ptr` increments.
- `rd_en` = (`read_en_N`|`read_en_E`|`read_en_W`|`read_en_S`|`read_en_L`) & !`empty`. On that edge `rd_ptr` increments.
  - The grants are one-hot by construction. If several are asserted, they still cause a single pop.
- `count` update per edge:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Boundary behaviour:
  - Pop while empty: ignored, no pointer or count change.
  - Full: `CTS` is not raised, so no overwrite is possible. A pop on a full FIFO frees a slot, and `CTS` may rise on the next cycle, not the same one.
  - Simultaneous push and pop with 0 < count < DEPTH: both take effect, count unchanged.
  - `DRTS` held high continuously: `CTS` alternates 1,0,1,0… and accepts at most one flit every 2 cycles.
- Reset, asynchronous on `rst`=0, from any state including mid-handshake:
  - `rd_ptr`=`wr_ptr`=0, count=0, `CTS`=0, `empty`=1, `full`=0.
  - Storage contents are not cleared, and `Data_out` is don't-care while empty.

## Timing
- `CTS` is registered. It rises 1 cycle after `DRTS` is sampled high with space available, and is high for exactly 1 cycle.
- Write latency: a flit presented with `DRTS` is visible on `Data_out` from the edge at which `CTS` rises (when the FIFO was empty). `empty` deasserts on that same edge.
- Read: `Data_out` is combinational from `rd_ptr`. After a pop edge, the next flit (or don't-care) appears in the same cycle.
- `full`, `empty` and `count` are registered-derived and change only on clock edges or asynchronous reset.

## Structure
- Shared router package: `DATA_WIDTH` default, `FIFO_DEPTH` constant, and the one-hot port-index constants (N, E, W, S, L) shared with the arbiter and crossbar.
- One natural sub-module: `fifo_handshake_ctrl`, holding `CTS_FF`, `wr_en` and `rd_en` generation. The storage array and pointers stay in the top module.

## Test plan
- Reset with `DRTS`=1 held → `CTS`=0, `empty`=1, `count`=0 during reset. First `CTS` pulse occurs 1 cycle after `rst` goes to 1.
- Single flit `RX`=0xDEADBEEF with `DRTS`=1 for 2 cycles → `CTS`=1 for 1 cycle, `Data_out`=0xDEADBEEF, `count`=1. Then `read_en_E`=1 for 1 cycle → `empty`=1.
- `DRTS` held high, no reads → `CTS` pulses 4 times on alternate cycles, `full`=1 and `count`=4, then `CTS` stays 0 indefinitely.
- FIFO full, `read_en_S`=1 for 1 cycle with `DRTS`=1 → `count` 4→3 on that edge, `CTS`=1 on the following edge, `count` back to 4. No data corruption; order is preserved across pointer wrap (write 6 flits, read 6 in order 0..5).
- Pop on empty with all five `read_en_*`=1 → pointers and `count` unchanged, `empty` stays 1. Two grants asserted on a 2-flit FIFO → exactly one pop.
- Assert `rst`=0 asynchronously mid-handshake (`CTS`=1, `count`=2) → `CTS`=0, `count`=0, `empty`=1 immediately, without waiting for a clock edge.
